// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, defaults and helpers for the signed sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // Callers sign-extend into 32 bits and truncate the result back to their width.
  function automatic logic [31:0] abs_w(input logic signed [31:0] x);
    return x[31] ? -x : x;
  endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// rtl/signed_seq_divider_if.sv - operand/result handshake bundle for the signed divider
interface signed_seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div_by_zero, ovf
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero, ovf
  );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on magnitudes
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign shifted          = {rem_i, bit_i};
  assign {borrow, diff}   = {1'b0, shifted} - {3'b000, dvs_i};
  assign qbit_o           = ~borrow;
  // Remainder stays below |b|, so the top bit of either candidate is always zero.
  assign rem_o            = (WIDTH+1)'(qbit_o ? diff : shifted);
endmodule

// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - iterative radix-2 restoring signed divider with handshakes
module signed_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  signed_seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic             pov_q, pov_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  assign quo_mag = {dvd_q[WIDTH-2:0], step_qbit};
  assign rem_mag = step_rem[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    pov_d   = pov_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          dvd_d   = WIDTH'(abs_w(32'(signed'(bus.a))));
          dvs_d   = WIDTH'(abs_w(32'(signed'(bus.b))));
          qneg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rneg_d  = bus.a[WIDTH-1];
          zero_d  = (bus.b == '0);
          pov_d   = (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
          cnt_d   = CW'(WIDTH);
          rem_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = quo_mag;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (zero_q) begin
            q_d   = '1;
            r_d   = a_q;
            dz_d  = 1'b1;
            ovf_d = 1'b0;
          end else begin
            q_d   = qneg_q ? -quo_mag : quo_mag;
            r_d   = rneg_q ? -rem_mag : rem_mag;
            dz_d  = 1'b0;
            ovf_d = pov_q;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      pov_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      pov_q   <= pov_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.div_by_zero = dz_q;
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_signed_seq_divider.sv
// tb/tb_signed_seq_divider.sv - scoreboard bench for the signed sequential divider
module tb_signed_seq_divider;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  signed_seq_divider_if #(.WIDTH(W)) bus ();
  signed_seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: SV integer division truncates toward zero, remainder follows dividend.
  function automatic exp_t model(input int ia, input int ib);
    exp_t e;
    int   qq, rr;
    e = '0;
    if (ib == 0) begin
      e.q  = '1;
      e.r  = ia[W-1:0];
      e.dz = 1'b1;
    end else if (ia == -8 && ib == -1) begin
      e.q   = 4'h8;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      qq  = ia / ib;
      rr  = ia % ib;
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
    end
    return e;
  endfunction

  task automatic issue(input int ia, input int ib);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.a        = ia[W-1:0];
    bus.b        = ib[W-1:0];
    bus.in_valid = 1'b1;
    sb.push_back(model(ia, ib));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic take(input int stall, output exp_t got, output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
    got = {bus.q, bus.r, bus.div_by_zero, bus.ovf};
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 4'd3;
    bus.b        = 4'd1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.q, bus.r, bus.div_by_zero, bus.ovf} !== {1'b1, 1'b0, 8'h00, 2'b00})
      $display("FAIL reset_state got rdy=%b ov=%b q=%h r=%h dz=%b ovf=%b want rdy=1 ov=0 q=0 r=0 dz=0 ovf=0",
               bus.in_ready, bus.out_valid, bus.q, bus.r, bus.div_by_zero, bus.ovf);
    if ({bus.in_ready, bus.out_valid, bus.q, bus.r, bus.div_by_zero, bus.ovf} !== {1'b1, 1'b0, 8'h00, 2'b00})
      errors++;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_accept got ov=%b rdy=%b want ov=0 rdy=1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_basic();
    int   ta[6] = '{-8, 7, -7, 4, -8, 5};
    int   tb[6] = '{7, -2, -2, 4, -1, 0};
    exp_t e, got;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i]);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready a=%0d b=%0d got rdy=%b want 0", ta[i], tb[i], bus.in_ready);
      end
      take(0, got, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL latency a=%0d b=%0d got %0d want %0d", ta[i], tb[i], lat, W);
      end
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL result a=%0d b=%0d got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=%b ovf=%b",
                 ta[i], tb[i], got.q, got.r, got.dz, got.ovf, e.q, e.r, e.dz, e.ovf);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL return_idle got ov=%b rdy=%b want ov=0 rdy=1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e, got;
    int   lat;
    issue(6, -4);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      got = {bus.q, bus.r, bus.div_by_zero, bus.ovf};
      checks++;
      if (got !== e || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold cyc=%0d got q=%h r=%h dz=%b ovf=%b rdy=%b ov=%b want q=%h r=%h dz=%b ovf=%b rdy=0 ov=1",
                 i, got.q, got.r, got.dz, got.ovf, bus.in_ready, bus.out_valid, e.q, e.r, e.dz, e.ovf);
      end
      bus.in_valid = (i == 4);
      bus.a        = 4'd1;
      bus.b        = 4'd1;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got rdy=%b ov=%b want rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
    issue(3, 2);
    take(0, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e || lat !== W) begin
      errors++;
      $display("FAIL after_bp got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", got.q, got.r, lat, e.q, e.r, W);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, got;
    int   lat;
    int   seen;
    issue(7, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    checks++;
    if (bus.out_valid !== 1'b0 || bus.q !== '0 || bus.r !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort got ov=%b q=%h r=%h rdy=%b want ov=0 q=0 r=0 rdy=1", bus.out_valid, bus.q, bus.r, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stale_result got valid_cycles=%0d rdy=%b want 0 and rdy=1", seen, bus.in_ready);
    end
    issue(-6, 4);
    take(0, got, lat);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL after_abort got q=%h r=%h want q=%h r=%h", got.q, got.r, e.q, e.r);
    end
  endtask

  task automatic test_exhaustive();
    exp_t e, got;
    int   lat, qi, ri, ar, ab;
    logic signed [2*W-1:0] prod;
    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        issue(ai, bi);
        take($urandom_range(0, 3), got, lat);
        e = sb.pop_front();
        checks++;
        if (got !== e || lat !== W) begin
          errors++;
          $display("FAIL exh a=%0d b=%0d got q=%h r=%h dz=%b ovf=%b lat=%0d want q=%h r=%h dz=%b ovf=%b lat=%0d",
                   ai, bi, got.q, got.r, got.dz, got.ovf, lat, e.q, e.r, e.dz, e.ovf, W);
        end
        if (bi != 0 && !(ai == -8 && bi == -1)) begin
          qi   = int'($signed(got.q));
          ri   = int'($signed(got.r));
          ar   = (ri < 0) ? -ri : ri;
          ab   = (bi < 0) ? -bi : bi;
          prod = (2*W)'(qi * bi);
          checks++;
          if (int'(prod) + ri != ai) begin
            errors++;
            $display("FAIL identity a=%0d b=%0d got q*b+r=%0d want %0d", ai, bi, int'(prod) + ri, ai);
          end
          checks++;
          if (ar >= ab) begin
            errors++;
            $display("FAIL rem_mag a=%0d b=%0d got |r|=%0d want < %0d", ai, bi, ar, ab);
          end
          checks++;
          if (ri != 0 && ((ri < 0) != (ai < 0))) begin
            errors++;
            $display("FAIL rem_sign a=%0d b=%0d got r=%0d want sign of a or 0", ai, bi, ri);
          end
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
